// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The bypass path is compiled in with WB_ARB_BYPASS_EN (see wb_port_arbiter.sv).
package wb_port_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic              killed;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } lu_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between WB stage / long-latency unit and the write-port arbiter.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    // LU handshake: a result transfers on a rising edge where lu_valid && lu_ready.
    // lu_valid, lu_rd and lu_data hold until then; lu_ready never depends on lu_valid.
    logic              lu_valid;
    logic [REG_AW-1:0] lu_rd;
    logic [XLEN-1:0]   lu_data;
    logic              lu_ready;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              stall_pipe;
    logic              lu_pending;

    modport slave (
        input  wb_valid, wb_reg_write, wb_rd, wb_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, lu_pending
    );

    modport master (
        output wb_valid, wb_reg_write, wb_rd, wb_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, lu_pending
    );

endinterface

// File: rtl/wb_lu_fifo.sv
// DEPTH-entry synchronous FIFO of LU results with a destination-register kill port.
module wb_lu_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_rd,
    output lu_entry_t         head,
    output logic              full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    lu_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].valid && (mem[i].rd == kill_rd)) mem[i].killed <= 1'b1;
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            // An LU result arriving alongside a younger WB write to the same rd is stale.
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, killed: kill_en && (push_rd == kill_rd),
                                 rd: push_rd, data: push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the WB stage and buffered LU results.
// Define WB_ARB_BYPASS_EN to let an LU result write directly when the port and FIFO are idle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    lu_entry_t         head;
    logic              full;
    logic              wb_req;
    logic              fifo_req;
    logic              force_grant;
    logic              grant_wb;
    logic              grant_fifo;
    logic              bypass;
    logic              push;
    logic [SW-1:0]     starve_cnt;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    assign wb_req      = bus.wb_valid && bus.wb_reg_write && (bus.wb_rd != ZERO_REG);
    assign fifo_req    = head.valid;
    assign force_grant = fifo_req && (starve_cnt == SW'(STARVE_LIMIT));
    assign grant_fifo  = fifo_req && (force_grant || !wb_req);
    assign grant_wb    = wb_req && !force_grant;

`ifdef WB_ARB_BYPASS_EN
    assign bypass = !fifo_req && !wb_req && bus.lu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = bus.lu_valid && !full && !bypass;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ZERO_REG;
        rf_wdata = '0;
        if (grant_wb) begin
            rf_we    = 1'b1;
            rf_waddr = bus.wb_rd;
            rf_wdata = bus.wb_data;
        end else if (grant_fifo) begin
            rf_we    = !head.killed && (head.rd != ZERO_REG);
            rf_waddr = head.rd;
            rf_wdata = head.data;
        end else if (bypass) begin
            rf_we    = (bus.lu_rd != ZERO_REG);
            rf_waddr = bus.lu_rd;
            rf_wdata = bus.lu_data;
        end
    end

    // Counts cycles a buffered result waits; reaching the limit steals the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!fifo_req || grant_fifo) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    wb_lu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (bus.lu_rd),
        .push_data (bus.lu_data),
        .pop       (grant_fifo),
        .kill_en   (grant_wb),
        .kill_rd   (bus.wb_rd),
        .head      (head),
        .full      (full)
    );

    assign bus.lu_ready   = !full;
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.stall_pipe = force_grant;
    assign bus.lu_pending = fifo_req;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: write-log scoreboard plus per-cycle output checks.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int W = REG_AW + XLEN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0]    exp_q[$];
    logic [XLEN-1:0] rf_model [32];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_wb(input logic v, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.wb_valid     = v;
        bus.wb_reg_write = v;
        bus.wb_rd        = rd;
        bus.wb_data      = d;
    endtask

    task automatic drive_lu(input logic v, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.lu_valid = v;
        bus.lu_rd    = rd;
        bus.lu_data  = d;
    endtask

    task automatic drive_idle();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_lu(1'b0, 5'd0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    // Every regfile write must match the next expected write, in order.
    always @(negedge clk) begin
        if (bus.rf_we) begin
            logic [W-1:0] exp_w;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("rf_write", {bus.rf_waddr, bus.rf_wdata}, exp_w);
            rf_model[bus.rf_waddr] = bus.rf_wdata;
        end
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_we", bus.rf_we, 0);
        check("rst_ready", bus.lu_ready, 1);
        check("rst_pending", bus.lu_pending, 0);
        check("rst_stall", bus.stall_pipe, 0);

        // Fill FIFO with two entries behind WB traffic, then reset mid-operation.
        next_cycle(); drive_wb(1, 5'd1, 32'h1000); drive_lu(1, 5'd2, 32'h2000); expect_write(5'd1, 32'h1000);
        next_cycle(); drive_wb(1, 5'd1, 32'h1001); drive_lu(1, 5'd4, 32'h4000); expect_write(5'd1, 32'h1001);
        @(negedge clk);
        check("fill_ready", bus.lu_ready, 1);
        next_cycle(); drive_wb(1, 5'd1, 32'h1002); drive_lu(0, 5'd0, 32'h0); expect_write(5'd1, 32'h1002);
        @(negedge clk);
        check("fill_full_ready", bus.lu_ready, 0);
        check("fill_pending", bus.lu_pending, 1);
        next_cycle(); drive_idle(); rst = 1'b1;
        @(negedge clk);
        check("midrst_pending", bus.lu_pending, 0);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("postrst_we", bus.rf_we, 0);
        check("postrst_pending", bus.lu_pending, 0);
        check("postrst_ready", bus.lu_ready, 1);

        // LU-only result with WB idle.
        next_cycle(); drive_lu(1, 5'd5, 32'hDEAD); expect_write(5'd5, 32'hDEAD);
        @(negedge clk);
`ifdef WB_ARB_BYPASS_EN
        check("lu_byp_we", bus.rf_we, 1);
        check("lu_byp_waddr", bus.rf_waddr, 5);
        next_cycle(); drive_idle();
        @(negedge clk);
        check("lu_byp_after_we", bus.rf_we, 0);
`else
        check("lu_q_same_we", bus.rf_we, 0);
        next_cycle(); drive_idle();
        @(negedge clk);
        check("lu_q_we", bus.rf_we, 1);
        check("lu_q_waddr", bus.rf_waddr, 5);
        check("lu_q_wdata", bus.rf_wdata, 32'hDEAD);
`endif

        // Starvation: WB writes rd=1 every cycle while rd=7 waits.
        next_cycle(); drive_wb(1, 5'd1, 32'h100); drive_lu(1, 5'd7, 32'h77); expect_write(5'd1, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); drive_wb(1, 5'd1, 32'h100 + 32'(k)); drive_lu(0, 5'd0, 32'h0);
            expect_write(5'd1, 32'h100 + 32'(k));
            @(negedge clk);
            check("starve_nostall", bus.stall_pipe, 0);
        end
        next_cycle(); drive_wb(1, 5'd1, 32'h105); expect_write(5'd7, 32'h77);
        @(negedge clk);
        check("starve_stall", bus.stall_pipe, 1);
        check("starve_waddr", bus.rf_waddr, 7);
        next_cycle(); expect_write(5'd1, 32'h105);
        @(negedge clk);
        check("starve_retry_stall", bus.stall_pipe, 0);
        check("starve_retry_waddr", bus.rf_waddr, 1);
        check("starve_pending", bus.lu_pending, 0);
        next_cycle(); drive_idle();

        // WAW: younger WB write to rd=3 kills the buffered LU result for rd=3.
        next_cycle(); drive_wb(1, 5'd9, 32'h99); drive_lu(1, 5'd3, 32'h11); expect_write(5'd9, 32'h99);
        next_cycle(); drive_wb(1, 5'd3, 32'h22); drive_lu(0, 5'd0, 32'h0); expect_write(5'd3, 32'h22);
        @(negedge clk);
        check("waw_pending", bus.lu_pending, 1);
        next_cycle(); drive_idle();
        @(negedge clk);
        check("waw_killed_we", bus.rf_we, 0);
        check("waw_killed_pending", bus.lu_pending, 1);
        next_cycle();
        @(negedge clk);
        check("waw_drained", bus.lu_pending, 0);
        check("waw_reg3", rf_model[3], 32'h22);

        // Back-pressure: full FIFO refuses the third result until a pop has happened.
        next_cycle(); drive_wb(1, 5'd2, 32'h200); drive_lu(1, 5'd10, 32'hA0); expect_write(5'd2, 32'h200);
        next_cycle(); drive_wb(1, 5'd2, 32'h201); drive_lu(1, 5'd11, 32'hB0); expect_write(5'd2, 32'h201);
        @(negedge clk);
        check("bp_ready_one", bus.lu_ready, 1);
        next_cycle(); drive_wb(1, 5'd2, 32'h202); drive_lu(1, 5'd12, 32'hC0); expect_write(5'd2, 32'h202);
        @(negedge clk);
        check("bp_ready_full", bus.lu_ready, 0);
        next_cycle(); drive_wb(0, 5'd0, 32'h0); expect_write(5'd10, 32'hA0);
        @(negedge clk);
        check("bp_ready_pop", bus.lu_ready, 0);
        check("bp_waddr10", bus.rf_waddr, 10);
        next_cycle(); expect_write(5'd11, 32'hB0);
        @(negedge clk);
        check("bp_ready_after", bus.lu_ready, 1);
        check("bp_waddr11", bus.rf_waddr, 11);
        next_cycle(); drive_idle(); expect_write(5'd12, 32'hC0);
        @(negedge clk);
        check("bp_waddr12", bus.rf_waddr, 12);
        next_cycle();
        @(negedge clk);
        check("bp_drained", bus.lu_pending, 0);

        // WB targeting x0 leaves the port to the FIFO; LU rd=0 is dropped.
        next_cycle(); drive_wb(1, 5'd4, 32'h400); drive_lu(1, 5'd6, 32'h66); expect_write(5'd4, 32'h400);
        next_cycle(); drive_wb(1, 5'd0, 32'hBAD); drive_lu(0, 5'd0, 32'h0); expect_write(5'd6, 32'h66);
        @(negedge clk);
        check("x0_we", bus.rf_we, 1);
        check("x0_waddr", bus.rf_waddr, 6);
        check("x0_wdata", bus.rf_wdata, 32'h66);
        next_cycle(); drive_wb(1, 5'd4, 32'h401); drive_lu(1, 5'd0, 32'h55); expect_write(5'd4, 32'h401);
        next_cycle(); drive_idle();
        @(negedge clk);
        check("lu_rd0_we", bus.rf_we, 0);
        check("lu_rd0_pending", bus.lu_pending, 1);
        next_cycle();
        @(negedge clk);
        check("lu_rd0_drained", bus.lu_pending, 0);
        check("reg0_clean", rf_model[0], 0);

        next_cycle();
        check("exp_q_drained", W'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
